// File: rtl/lsu_agu.sv
// Execute-stage load/store unit: effective address, alignment check, req/gnt + rvalid
// data-memory bus, pipeline stall and sign/zero-extended load writeback.
module lsu_agu #(
  parameter int unsigned DECODE_INFO_BUS_WIDTH = 14,
  parameter logic [2:0]  MEM_TYPE              = 3'b010
) (
  input  logic                             clk_sys,
  input  logic                             rst_sys,
  input  logic                             i_valid,
  input  logic                             i_flush,
  input  logic [DECODE_INFO_BUS_WIDTH-1:0] i_decode_info_bus,
  input  logic [31:0]                      i_rs1data,
  input  logic [31:0]                      i_rs2data,
  input  logic [31:0]                      i_imm,
  input  logic [4:0]                       i_rdidx,
  output logic                             o_mem_req,
  input  logic                             i_mem_gnt,
  output logic [31:0]                      o_mem_addr,
  output logic                             o_mem_we,
  output logic [3:0]                       o_mem_wstrb,
  output logic [31:0]                      o_mem_wdata,
  input  logic                             i_mem_rvalid,
  input  logic [31:0]                      i_mem_rdata,
  input  logic                             i_mem_err,
  output logic                             o_lsu_stall,
  output logic                             o_wb_valid,
  output logic [4:0]                       o_wb_rdidx,
  output logic [31:0]                      o_wb_data,
  output logic                             o_misalign,
  output logic                             o_bus_err
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RIDXW = 5;
  localparam logic [1:0]  SZ_B  = 2'd0;
  localparam logic [1:0]  SZ_H  = 2'd1;
  localparam logic [1:0]  SZ_W  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state_q;
  logic              load_q;
  logic              sext_q;
  logic [1:0]        size_q;
  logic [RIDXW-1:0]  rdidx_q;

  logic [7:0]        op_c;
  logic [XLEN-1:0]   addr_c;
  logic              accept_c;
  logic              misal_c;
  logic              go_c;
  logic              store_c;
  logic [1:0]        size_c;
  logic [3:0]        st_wstrb_c;
  logic [XLEN-1:0]   st_wdata_c;
  logic [XLEN-1:0]   lane_c;
  logic [XLEN-1:0]   ld_data_c;
  logic              unused_c;

  // Op bits 8..10 carry nothing this unit needs.
  assign unused_c = ^i_decode_info_bus[10:8];

  // Decode, address generation, alignment and store lane formatting.
  always_comb begin
    op_c       = i_decode_info_bus[7:0];
    addr_c     = i_rs1data + i_imm;
    accept_c   = (state_q == S_IDLE) & i_valid & ~i_flush &
                 (i_decode_info_bus[13:11] == MEM_TYPE) & $onehot(op_c);
    misal_c    = ((op_c[1] | op_c[4] | op_c[6]) & addr_c[0]) |
                 ((op_c[2] | op_c[7]) & (addr_c[1:0] != 2'b00));
    go_c       = accept_c & ~misal_c;
    store_c    = |op_c[7:5];
    size_c     = SZ_W;
    st_wstrb_c = '0;
    st_wdata_c = '0;
    if (op_c[0] | op_c[3] | op_c[5]) begin
      size_c = SZ_B;
    end else if (op_c[1] | op_c[4] | op_c[6]) begin
      size_c = SZ_H;
    end
    if (op_c[5]) begin
      st_wdata_c = {4{i_rs2data[7:0]}};
      st_wstrb_c = 4'b0001 << addr_c[1:0];
    end else if (op_c[6]) begin
      st_wdata_c = {2{i_rs2data[15:0]}};
      st_wstrb_c = addr_c[1] ? 4'b1100 : 4'b0011;
    end else if (op_c[7]) begin
      st_wdata_c = i_rs2data;
      st_wstrb_c = 4'b1111;
    end
  end

  // Bus handshake and pipeline hold.
  always_comb begin
    o_mem_req   = (state_q == S_REQ);
    o_lsu_stall = go_c | (state_q == S_REQ) | ((state_q == S_WAIT) & ~i_mem_rvalid);
  end

  // Load extraction: shift the addressed lane down, then extend by size.
  always_comb begin
    lane_c    = i_mem_rdata >> {o_mem_addr[1:0], 3'b000};
    ld_data_c = i_mem_rdata;
    case (size_q)
      SZ_B:    ld_data_c = {{24{sext_q & lane_c[7]}}, lane_c[7:0]};
      SZ_H:    ld_data_c = {{16{sext_q & lane_c[15]}}, lane_c[15:0]};
      default: ld_data_c = i_mem_rdata;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      state_q     <= S_IDLE;
      load_q      <= 1'b0;
      sext_q      <= 1'b0;
      size_q      <= SZ_B;
      rdidx_q     <= '0;
      o_mem_addr  <= '0;
      o_mem_we    <= 1'b0;
      o_mem_wstrb <= '0;
      o_mem_wdata <= '0;
      o_wb_valid  <= 1'b0;
      o_wb_rdidx  <= '0;
      o_wb_data   <= '0;
      o_misalign  <= 1'b0;
      o_bus_err   <= 1'b0;
    end else begin
      o_misalign <= accept_c & misal_c;
      o_wb_valid <= 1'b0;
      o_bus_err  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go_c) begin
            state_q     <= S_REQ;
            o_mem_addr  <= addr_c;
            o_mem_we    <= store_c;
            o_mem_wstrb <= st_wstrb_c;
            o_mem_wdata <= st_wdata_c;
            load_q      <= ~store_c;
            sext_q      <= op_c[0] | op_c[1];
            size_q      <= size_c;
            rdidx_q     <= i_rdidx;
          end
        end
        S_REQ: begin
          if (i_mem_gnt) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i_mem_rvalid) begin
            state_q <= S_IDLE;
            if (i_mem_err) begin
              o_bus_err <= 1'b1;
            end else if (load_q) begin
              o_wb_valid <= 1'b1;
              o_wb_data  <= ld_data_c;
              o_wb_rdidx <= rdidx_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_agu.sv
// Bench for lsu_agu: directed vector table, reset-in-flight sequence and
// randomized ops checked against an arithmetic reference model.
module tb_lsu_agu;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic        i_valid, i_flush;
  logic [13:0] i_decode_info_bus;
  logic [31:0] i_rs1data, i_rs2data, i_imm;
  logic [4:0]  i_rdidx;
  logic        o_mem_req, i_mem_gnt;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [3:0]  o_mem_wstrb;
  logic [31:0] o_mem_wdata;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        i_mem_err;
  logic        o_lsu_stall, o_wb_valid;
  logic [4:0]  o_wb_rdidx;
  logic [31:0] o_wb_data;
  logic        o_misalign, o_bus_err;

  int checks = 0;
  int failures = 0;

  lsu_agu dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .i_valid(i_valid), .i_flush(i_flush),
    .i_decode_info_bus(i_decode_info_bus), .i_rs1data(i_rs1data), .i_rs2data(i_rs2data),
    .i_imm(i_imm), .i_rdidx(i_rdidx), .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wstrb(o_mem_wstrb),
    .o_mem_wdata(o_mem_wdata), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .i_mem_err(i_mem_err), .o_lsu_stall(o_lsu_stall), .o_wb_valid(o_wb_valid),
    .o_wb_rdidx(o_wb_rdidx), .o_wb_data(o_wb_data), .o_misalign(o_misalign),
    .o_bus_err(o_bus_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [13:0] bus;
    logic        flush;
    logic [31:0] rs1, imm, rs2;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
    int          gdly, rdly;
    logic        acc, mis;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        wb;
    logic [31:0] wbdata;
  } vec_t;

  vec_t tbl[$];

  localparam int LB = 0, LH = 1, LW = 2, LBU = 3, LHU = 4, SB = 5, SH = 6, SW = 7;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [13:0] ob(input int idx);
    logic [7:0] oh;
    oh = 8'(1 << idx);
    return {3'b010, 3'b000, oh};
  endfunction

  function automatic vec_t mk(input logic [13:0] bus, input logic flush, input logic [31:0] rs1,
      input logic [31:0] imm, input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] rdata,
      input logic err, input int gdly, input int rdly, input logic acc, input logic mis,
      input logic [31:0] addr, input logic we, input logic [3:0] wstrb, input logic [31:0] wdata,
      input logic wb, input logic [31:0] wbdata);
    vec_t v;
    v.bus = bus; v.flush = flush; v.rs1 = rs1; v.imm = imm; v.rs2 = rs2; v.rd = rd;
    v.rdata = rdata; v.err = err; v.gdly = gdly; v.rdly = rdly; v.acc = acc; v.mis = mis;
    v.addr = addr; v.we = we; v.wstrb = wstrb; v.wdata = wdata; v.wb = wb; v.wbdata = wbdata;
    return v;
  endfunction

  // Reference model: sizes in bytes, lanes and extension by plain arithmetic.
  function automatic vec_t model(input vec_t vin);
    vec_t v;
    int idx, size, off;
    bit store, sgn, take;
    longint val;
    v = vin;
    idx = 0;
    for (int i = 0; i < 8; i++) if (v.bus[i]) idx = i;
    take  = (v.bus[13:11] == 3'b010) && ($countones(v.bus[7:0]) == 1) && !v.flush;
    size  = (idx == LW || idx == SW) ? 4 : (idx == LH || idx == LHU || idx == SH) ? 2 : 1;
    store = (idx >= SB);
    sgn   = (idx == LB || idx == LH);
    v.addr = v.rs1 + v.imm;
    off   = int'(v.addr % 4);
    v.mis = take && ((v.addr % size) != 0);
    v.acc = take && ((v.addr % size) == 0);
    v.we  = store;
    v.wstrb = store ? 4'(((1 << size) - 1) << off) : 4'h0;
    if (!store) v.wdata = 32'h0;
    else if (size == 1) v.wdata = (v.rs2 & 32'hFF) * 32'h01010101;
    else if (size == 2) v.wdata = (v.rs2 & 32'hFFFF) * 32'h00010001;
    else v.wdata = v.rs2;
    val = longint'(v.rdata >> (8 * off)) % (64'sd1 << (8 * size));
    if (sgn && val >= (64'sd1 << (8 * size - 1))) val = val - (64'sd1 << (8 * size));
    v.wbdata = 32'(val);
    v.wb = v.acc && !store && !v.err;
    return v;
  endfunction

  // Drive one op through accept, request, wait and writeback, checking every cycle.
  task automatic run(input vec_t v);
    @(negedge clk_sys);
    i_valid = 1'b1; i_flush = v.flush; i_decode_info_bus = v.bus;
    i_rs1data = v.rs1; i_imm = v.imm; i_rs2data = v.rs2; i_rdidx = v.rd;
    #1 chk("stall_accept", 32'(o_lsu_stall), 32'(v.acc));
    @(negedge clk_sys);
    i_valid = 1'b0; i_flush = 1'b0;
    #1 chk("misalign", 32'(o_misalign), 32'(v.mis));
    if (!v.acc) begin
      chk("req_idle", 32'(o_mem_req), 32'h0);
      chk("stall_idle", 32'(o_lsu_stall), 32'h0);
      @(negedge clk_sys);
      #1 chk("misalign_pulse", 32'(o_misalign), 32'h0);
      chk("req_idle2", 32'(o_mem_req), 32'h0);
      return;
    end
    for (int k = 0; k <= v.gdly; k++) begin
      if (k > 0) @(negedge clk_sys);
      i_mem_gnt = (k == v.gdly);
      i_flush = 1'($urandom_range(0, 1));
      #1;
      chk("req", 32'(o_mem_req), 32'h1);
      chk("addr", o_mem_addr, v.addr);
      chk("we", 32'(o_mem_we), 32'(v.we));
      chk("wstrb", 32'(o_mem_wstrb), 32'(v.wstrb));
      chk("wdata", o_mem_wdata, v.wdata);
      chk("stall_req", 32'(o_lsu_stall), 32'h1);
    end
    @(negedge clk_sys);
    i_mem_gnt = 1'b0;
    #1 chk("req_drop", 32'(o_mem_req), 32'h0);
    for (int j = 0; j <= v.rdly; j++) begin
      if (j > 0) @(negedge clk_sys);
      i_mem_rvalid = (j == v.rdly);
      i_mem_rdata = (j == v.rdly) ? v.rdata : 32'($urandom);
      i_mem_err = (j == v.rdly) ? v.err : 1'b0;
      i_flush = 1'($urandom_range(0, 1));
      #1 chk("stall_wait", 32'(o_lsu_stall), 32'(j != v.rdly));
    end
    @(negedge clk_sys);
    i_mem_rvalid = 1'b0; i_mem_err = 1'b0; i_flush = 1'b0;
    #1 chk("wb_valid", 32'(o_wb_valid), 32'(v.wb));
    if (v.wb) begin
      chk("wb_data", o_wb_data, v.wbdata);
      chk("wb_rdidx", 32'(o_wb_rdidx), 32'(v.rd));
    end
    chk("bus_err", 32'(o_bus_err), 32'(v.err));
    chk("stall_done", 32'(o_lsu_stall), 32'h0);
    @(negedge clk_sys);
    #1 chk("wb_pulse", 32'(o_wb_valid), 32'h0);
    chk("err_pulse", 32'(o_bus_err), 32'h0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_req"}, 32'(o_mem_req), 32'h0);
    chk({nm, "_stall"}, 32'(o_lsu_stall), 32'h0);
    chk({nm, "_bus"}, {o_mem_addr ^ o_mem_wdata, 28'h0}
        | 32'({o_mem_we, o_mem_wstrb}), 32'h0);
    chk({nm, "_wb"}, 32'({o_wb_valid, o_wb_rdidx, o_misalign, o_bus_err}), 32'h0);
    chk({nm, "_wbdata"}, o_wb_data, 32'h0);
    chk({nm, "_addr"}, o_mem_addr, 32'h0);
  endtask

  initial begin
    vec_t v;
    rst_sys = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_decode_info_bus = '0;
    i_rs1data = '0; i_rs2data = '0; i_imm = '0; i_rdidx = '0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_mem_err = 1'b0;

    //              bus     fl  rs1           imm           rs2           rd  rdata        er g r  acc mis addr          we wstrb  wdata         wb wbdata
    tbl.push_back(mk(ob(LW), 0, 32'h1000,     32'h4,        32'h0,        5, 32'hDEADBEEF, 0, 0, 1, 1, 0, 32'h1004,     0, 4'h0, 32'h0,        1, 32'hDEADBEEF));
    tbl.push_back(mk(ob(LB), 0, 32'h1000,     32'h3,        32'h0,        7, 32'h80112233, 0, 0, 0, 1, 0, 32'h1003,     0, 4'h0, 32'h0,        1, 32'hFFFFFF80));
    tbl.push_back(mk(ob(LBU),0, 32'h1000,     32'h3,        32'h0,        8, 32'h80112233, 0, 1, 0, 1, 0, 32'h1003,     0, 4'h0, 32'h0,        1, 32'h00000080));
    tbl.push_back(mk(ob(LH), 0, 32'h1000,     32'h2,        32'h0,        9, 32'h80112233, 0, 0, 2, 1, 0, 32'h1002,     0, 4'h0, 32'h0,        1, 32'hFFFF8011));
    tbl.push_back(mk(ob(LHU),0, 32'h1000,     32'h2,        32'h0,       10, 32'h80112233, 0, 0, 0, 1, 0, 32'h1002,     0, 4'h0, 32'h0,        1, 32'h00008011));
    tbl.push_back(mk(ob(SH), 0, 32'h2000,     32'h2,        32'h1234ABCD, 3, 32'h0,        0, 0, 1, 1, 0, 32'h2002,     1, 4'hC, 32'hABCDABCD, 0, 32'h0));
    tbl.push_back(mk(ob(LW), 0, 32'h1000,     32'h2,        32'h0,        5, 32'h0,        0, 0, 0, 0, 1, 32'h1002,     0, 4'h0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(ob(SW), 0, 32'h3000,     32'h0,        32'hCAFEF00D, 4, 32'h0,        1, 3, 1, 1, 0, 32'h3000,     1, 4'hF, 32'hCAFEF00D, 0, 32'h0));
    tbl.push_back(mk(ob(SB), 0, 32'h10,       32'h1,        32'h123456A5, 2, 32'h0,        0, 2, 0, 1, 0, 32'h11,       1, 4'h2, 32'hA5A5A5A5, 0, 32'h0));
    tbl.push_back(mk(ob(LW), 1, 32'h1000,     32'h0,        32'h0,        5, 32'h0,        0, 0, 0, 0, 0, 32'h1000,     0, 4'h0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(14'b010_000_00000011, 0, 32'h1000, 32'h0, 32'h0, 5, 32'h0,         0, 0, 0, 0, 0, 32'h1000,     0, 4'h0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(ob(LH), 0, 32'h1001,     32'h0,        32'h0,        5, 32'h0,        0, 0, 0, 0, 1, 32'h1001,     0, 4'h0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(14'b011_000_00000100, 0, 32'h1000, 32'h0, 32'h0, 5, 32'h0,         0, 0, 0, 0, 0, 32'h1000,     0, 4'h0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(ob(LB), 0, 32'h1004,     32'hFFFFFFFF, 32'h0,       11, 32'h7F000000, 0, 0, 0, 1, 0, 32'h1003,     0, 4'h0, 32'h0,        1, 32'h0000007F));
    tbl.push_back(mk(ob(LW), 0, 32'hFFFFFFFC, 32'h8,        32'h0,       12, 32'h12345678, 0, 1, 3, 1, 0, 32'h4,        0, 4'h0, 32'h0,        1, 32'h12345678));

    repeat (3) @(negedge clk_sys);
    #1 chk_all_zero("reset");
    rst_sys = 1'b1;

    foreach (tbl[i]) run(tbl[i]);

    // Reset while the load waits for its response: nothing may be reported.
    @(negedge clk_sys);
    i_valid = 1'b1; i_decode_info_bus = ob(LW); i_rs1data = 32'h40; i_imm = 32'h0; i_rdidx = 5'd9;
    @(negedge clk_sys);
    i_valid = 1'b0; i_mem_gnt = 1'b1;
    @(negedge clk_sys);
    i_mem_gnt = 1'b0;
    #1 chk("rst_pre_stall", 32'(o_lsu_stall), 32'h1);
    @(negedge clk_sys);
    rst_sys = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h55AA55AA;
    #1 chk_all_zero("rst_mid");
    @(negedge clk_sys);
    i_mem_rvalid = 1'b0;
    @(negedge clk_sys);
    rst_sys = 1'b1;
    @(negedge clk_sys);
    #1 chk("rst_post_wb", 32'(o_wb_valid), 32'h0);
    chk("rst_post_req", 32'(o_mem_req), 32'h0);
    chk("rst_post_err", 32'(o_bus_err), 32'h0);
    run(tbl[0]);

    for (int n = 0; n < 80; n++) begin
      int r;
      v = tbl[0];
      v.bus = ob($urandom_range(0, 7));
      v.bus[10:8] = 3'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) v.bus[13:11] = 3'($urandom);
      if (r == 1) v.bus[7:0] = v.bus[7:0] | 8'(1 << $urandom_range(0, 7));
      v.flush = ($urandom_range(0, 7) == 0);
      v.rs1 = $urandom;
      v.imm = 32'($urandom_range(0, 15)) - 32'd8;
      if ($urandom_range(0, 1) == 1) begin
        v.rs1 = v.rs1 & ~32'h3;
        v.imm = v.imm & ~32'h3;
      end
      v.rs2 = $urandom; v.rdata = $urandom; v.rd = 5'($urandom);
      v.err = ($urandom_range(0, 4) == 0);
      v.gdly = $urandom_range(0, 3); v.rdly = $urandom_range(0, 3);
      run(model(v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
